store_serializer: RTL and testbench
===================================

Name: store_serializer

Overview:
- Memory-side counterpart to the CPU's load-path sign/zero extension. Extension widens narrow memory data into a 32-bit register value; this block narrows a 32-bit register value for sb, sh and sw stores.
- It writes the value onto an 8-bit data-memory write bus, one byte per memory handshake.
- Sits between the MEM stage and a byte-wide data RAM or peripheral bus.
- Handles size decode, alignment checking, byte ordering and the per-byte write handshake.

Parameters:
- AW, 32, address width of req_addr and mem_addr.
- DW, 32, register data width; must be a multiple of 8, and only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  store request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_addr  input  AW  byte address of the store
- req_data  input  DW  register value; low bytes are stored
- req_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal
- mem_we  output  1  byte write request to memory
- mem_addr  output  AW  byte address of the current write
- mem_wdata  output  8  byte being written
- mem_ack  input  1  memory accepted the current byte this cycle
- done  output  1  one-cycle pulse: store completed
- misalign  output  1  one-cycle pulse: store rejected, no bytes written

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: req_ready = 1, mem_we = 0, mem_addr = 0, mem_wdata = 0, done = 0, misalign = 0, FSM in IDLE, byte counter = 0.
- Accept: a request is accepted on a rising edge where req_valid && req_ready. On acceptance the block latches req_addr, req_data and req_size.
- Byte count N: byte = 1, half = 2, word = 4.
- Alignment rule, checked at acceptance:
  - A half is misaligned if addr[0] = 1.
  - A word is misaligned if addr[1:0] != 0.
  - req_size = 11 is always rejected.
  - On rejection: go to ERR for one cycle, pulse misalign, issue no mem_we, then return to IDLE.
- Byte order is little-endian. Write k (k = 0..N-1) has mem_addr = addr + k and mem_wdata = data[8k+7:8k].
- FSM states: IDLE, WRITE, DONE, ERR.
  - IDLE: req_ready = 1. On accept, go to WRITE (aligned) or ERR (misaligned). mem_we is driven high in the same edge that enters WRITE.
  - WRITE: hold mem_we, mem_addr and mem_wdata stable until mem_ack.
    - On mem_ack with k < N-1: increment k, update address and data, keep mem_we high. Back-to-back bytes are allowed, one byte per cycle when ack is held high.
    - On mem_ack with k = N-1: drop mem_we and go to DONE.
  - DONE: pulse done for 1 cycle, then go to IDLE.
  - ERR: pulse misalign for 1 cycle, then go to IDLE.
- Latency:
  - Accept to first mem_we: 1 cycle.
  - A word with mem_ack tied high: mem_we is high for 4 cycles, done follows in the next cycle, and the block is ready again 1 cycle after done (6 cycles accept to ready).
- Ignored inputs:
  - mem_ack while mem_we = 0 is ignored.
  - req_valid outside IDLE is ignored; req_ready = 0 there.
- Address wrap: addr + k wraps modulo 2^AW. No special handling is required, since aligned accesses never cross a word.
- Reset mid-operation: rst aborts immediately to reset values. Bytes already acknowledged stay written; no rollback is performed and no done is pulsed.
- Simultaneous done and a new request: not possible, because req_ready = 0 in DONE. The next accept occurs no earlier than the cycle after done.

Decomposition:
- Shared package (cpu_pkg):
  - Size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - FSM state encoding.
  - A function returning byte count and misalign flag from (size, addr[1:0]). This function is reused by the load-side extension control.
- No sub-module is needed; the block is a single FSM plus a 2-bit byte counter.

Test Plan:
- sw: req_addr = 0x100, req_data = 0xA1B2C3D4, size = 10, mem_ack tied 1 -> writes (0x100, D4), (0x101, C3), (0x102, B2), (0x103, A1) on 4 consecutive cycles, done pulses on the next cycle, req_ready returns the cycle after.
- sh with waits: addr = 0x202, data = 0xFFFF1234, size = 01, ack delayed 3 cycles per byte -> mem_addr / mem_wdata held at (0x202, 34) until ack, then (0x203, 12); exactly 2 acks consumed; done pulses once.
- sb: addr = 0x7, data = 0x000000EE, size = 00 -> a single write (0x7, EE), done pulses, no further mem_we.
- Misaligned and illegal requests:
  - sw at 0x102 -> misalign pulses 1 cycle after accept, mem_we stays 0, done stays 0.
  - sh at 0x3 -> same response.
  - size = 11 at 0x0 -> same response.
- Reset mid-word: assert rst after the 2nd ack of an sw -> mem_we drops immediately (asynchronously), no done pulse; after release req_ready = 1 and a fresh sb completes normally.
- Back-pressure: hold req_valid high with a new request during WRITE -> it is not accepted until IDLE, and it is processed exactly once.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU memory-path definitions: access-size encodings, store FSM states
// and the size/alignment decoder used by both the store and load paths.
package cpu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    // last_idx is the byte count minus one, so it fits the 2-bit byte counter.
    typedef struct packed {
        logic [1:0] last_idx;
        logic       misalign;
    } size_info_t;

    function automatic size_info_t decode_size(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        size_info_t info;
        info.last_idx = 2'd0;
        info.misalign = 1'b0;
        case (size)
            SZ_BYTE: info.last_idx = 2'd0;
            SZ_HALF: begin
                info.last_idx = 2'd1;
                info.misalign = addr_lo[0];
            end
            SZ_WORD: begin
                info.last_idx = 2'd3;
                info.misalign = |addr_lo;
            end
            default: info.misalign = 1'b1;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/store_serializer_if.sv
// Store request channel plus byte-wide memory write channel of the serializer.
interface store_serializer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [1:0]    req_size;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_ack;
    logic          done;
    logic          misalign;

    // master: the MEM stage and memory side; slave: the serializer itself.
    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ack,
        input  req_ready, mem_we, mem_addr, mem_wdata, done, misalign
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ack,
        output req_ready, mem_we, mem_addr, mem_wdata, done, misalign
    );
endinterface

// File: rtl/store_serializer.sv
// Narrows a 32-bit sb/sh/sw store onto a byte-wide write bus, little-endian,
// one byte per mem_ack; misaligned or illegal stores are rejected with a pulse.
module store_serializer
    import cpu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32   // only 32 is supported
) (
    input  logic                clk,
    input  logic                rst,
    store_serializer_if.slave   bus
);

    state_t        state_q, state_d;
    size_info_t    info;
    logic [1:0]    k_q;
    logic [1:0]    last_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    wdata_q;
    logic [DW-1:0] data_q;   // bytes still to be written, next one in [7:0]
    logic          accept;
    logic          byte_ack;
    logic          last_byte;

    assign info      = decode_size(bus.req_size, bus.req_addr[1:0]);
    assign accept    = (state_q == ST_IDLE) && bus.req_valid;
    assign byte_ack  = (state_q == ST_WRITE) && bus.mem_ack;
    assign last_byte = (k_q == last_q);

    // NOTE: every output of this block takes its default before the case, so no latch can form.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.req_valid) state_d = info.misalign ? ST_ERR : ST_WRITE;
            ST_WRITE: if (bus.mem_ack && last_byte) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q     <= 2'd0;
            last_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            data_q  <= '0;
        end else if (accept && !info.misalign) begin
            k_q     <= 2'd0;
            last_q  <= info.last_idx;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_data[7:0];
            data_q  <= bus.req_data >> 8;
        end else if (byte_ack && !last_byte) begin
            // Wraps modulo 2^AW; aligned accesses never cross a word anyway.
            k_q     <= k_q + 2'd1;
            addr_q  <= addr_q + AW'(1);
            wdata_q <= data_q[7:0];
            data_q  <= data_q >> 8;
        end
    end

    // Outputs decode straight from the state register, so they are glitch-free
    // and drop the moment the asynchronous reset hits.
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.mem_we    = (state_q == ST_WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.done      = (state_q == ST_DONE);
    assign bus.misalign  = (state_q == ST_ERR);

endmodule

// File: tb/tb_store_serializer.sv
// Directed self-checking bench for store_serializer: sw/sh/sb writes, wait
// states, misaligned and illegal sizes, mid-store reset and request back-pressure.
module tb_store_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   ack_cnt  = 0;
    int   done_cnt = 0;
    int   b_cnt    = 0;
    int   ack_base;
    int   done_base;

    store_serializer_if #(.AW(32), .DW(32)) bus ();

    store_serializer #(.AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Bench-side observation of handshakes actually consumed at each edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.mem_we && bus.mem_ack) begin
                ack_cnt++;
                if (bus.mem_addr == 32'h0000_0500) b_cnt++;
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] addr, input logic [7:0] data);
        check({tag, " mem_we"},    32'(bus.mem_we),    32'd1);
        check({tag, " mem_addr"},  bus.mem_addr,       addr);
        check({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'(data));
    endtask

    task automatic request(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_size  = size;
    endtask

    logic [31:0] bad_addr [3] = '{32'h0000_0102, 32'h0000_0003, 32'h0000_0000};
    logic [1:0]  bad_size [3] = '{2'b10, 2'b01, 2'b11};

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_size  = 2'b00;
        bus.mem_ack   = 1'b0;

        // Reset values
        tick();
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        check("rst mem_we",    32'(bus.mem_we),    32'd0);
        check("rst mem_addr",  bus.mem_addr,       32'd0);
        check("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst done",      32'(bus.done),      32'd0);
        check("rst misalign",  32'(bus.misalign),  32'd0);
        rst = 1'b0;
        tick();

        // sw, ack tied high: four back-to-back bytes, done, then ready
        bus.mem_ack = 1'b1;
        request(32'h0000_0100, 32'hA1B2_C3D4, 2'b10);
        tick();
        bus.req_valid = 1'b0;
        check("sw busy", 32'(bus.req_ready), 32'd0);
        expect_write("sw b0", 32'h0000_0100, 8'hD4); tick();
        expect_write("sw b1", 32'h0000_0101, 8'hC3); tick();
        expect_write("sw b2", 32'h0000_0102, 8'hB2); tick();
        expect_write("sw b3", 32'h0000_0103, 8'hA1); tick();
        check("sw we off", 32'(bus.mem_we),    32'd0);
        check("sw done",   32'(bus.done),      32'd1);
        check("sw ready0", 32'(bus.req_ready), 32'd0);
        tick();
        check("sw done off", 32'(bus.done),      32'd0);
        check("sw ready",    32'(bus.req_ready), 32'd1);

        // sh with three wait cycles per byte
        bus.mem_ack = 1'b0;
        ack_base  = ack_cnt;
        done_base = done_cnt;
        request(32'h0000_0202, 32'hFFFF_1234, 2'b01);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_write("sh hold0", 32'h0000_0202, 8'h34);
            tick();
        end
        bus.mem_ack = 1'b1;
        expect_write("sh ack0", 32'h0000_0202, 8'h34);
        tick();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_write("sh hold1", 32'h0000_0203, 8'h12);
            tick();
        end
        bus.mem_ack = 1'b1;
        expect_write("sh ack1", 32'h0000_0203, 8'h12);
        tick();
        bus.mem_ack = 1'b0;
        check("sh we off", 32'(bus.mem_we), 32'd0);
        check("sh done",   32'(bus.done),   32'd1);
        tick();
        check("sh ready", 32'(bus.req_ready),  32'd1);
        check("sh acks",  ack_cnt - ack_base,   32'd2);
        check("sh dones", done_cnt - done_base, 32'd1);

        // sb: a single byte
        bus.mem_ack = 1'b1;
        ack_base = ack_cnt;
        request(32'h0000_0007, 32'h0000_00EE, 2'b00);
        tick();
        bus.req_valid = 1'b0;
        expect_write("sb b0", 32'h0000_0007, 8'hEE);
        tick();
        check("sb we off", 32'(bus.mem_we), 32'd0);
        check("sb done",   32'(bus.done),   32'd1);
        tick();
        check("sb we idle", 32'(bus.mem_we),    32'd0);
        check("sb ready",   32'(bus.req_ready), 32'd1);
        check("sb acks",    ack_cnt - ack_base, 32'd1);

        // Misaligned sw, misaligned sh, illegal size: rejected, ack ignored
        ack_base  = ack_cnt;
        done_base = done_cnt;
        for (int i = 0; i < 3; i++) begin
            request(bad_addr[i], 32'hDEAD_BEEF, bad_size[i]);
            tick();
            bus.req_valid = 1'b0;
            check("bad misalign", 32'(bus.misalign),  32'd1);
            check("bad mem_we",   32'(bus.mem_we),    32'd0);
            check("bad done",     32'(bus.done),      32'd0);
            check("bad busy",     32'(bus.req_ready), 32'd0);
            tick();
            check("bad misalign off", 32'(bus.misalign),  32'd0);
            check("bad ready",        32'(bus.req_ready), 32'd1);
            check("bad mem_we idle",  32'(bus.mem_we),    32'd0);
        end
        check("bad acks",  ack_cnt - ack_base,   32'd0);
        check("bad dones", done_cnt - done_base, 32'd0);

        // Reset after the second ack of an sw: immediate abort, no done
        done_base = done_cnt;
        request(32'h0000_0300, 32'h1122_3344, 2'b10);
        tick();
        bus.req_valid = 1'b0;
        expect_write("rw b0", 32'h0000_0300, 8'h44); tick();
        expect_write("rw b1", 32'h0000_0301, 8'h33); tick();
        expect_write("rw b2", 32'h0000_0302, 8'h22);
        #2 rst = 1'b1;
        #1;
        check("rw we async",  32'(bus.mem_we),    32'd0);
        check("rw ready",     32'(bus.req_ready), 32'd1);
        check("rw mem_addr",  bus.mem_addr,       32'd0);
        check("rw done",      32'(bus.done),      32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rw no done", done_cnt - done_base, 32'd0);
        check("rw ready2",  32'(bus.req_ready),   32'd1);
        request(32'h0000_0055, 32'h0000_00AB, 2'b00);
        tick();
        bus.req_valid = 1'b0;
        expect_write("rw sb", 32'h0000_0055, 8'hAB);
        tick();
        check("rw sb done", 32'(bus.done), 32'd1);
        tick();

        // Back-pressure: second request held valid during WRITE
        bus.mem_ack = 1'b0;
        request(32'h0000_0400, 32'h0000_5678, 2'b01);
        tick();
        request(32'h0000_0500, 32'h0000_0099, 2'b00);
        for (int i = 0; i < 2; i++) begin
            check("bp busy", 32'(bus.req_ready), 32'd0);
            expect_write("bp a0", 32'h0000_0400, 8'h78);
            tick();
        end
        bus.mem_ack = 1'b1;
        tick();
        expect_write("bp a1", 32'h0000_0401, 8'h56);
        tick();
        check("bp a done",  32'(bus.done),      32'd1);
        check("bp a busy",  32'(bus.req_ready), 32'd0);
        check("bp a we",    32'(bus.mem_we),    32'd0);
        tick();
        check("bp idle ready", 32'(bus.req_ready), 32'd1);
        check("bp idle we",    32'(bus.mem_we),    32'd0);
        tick();
        bus.req_valid = 1'b0;
        expect_write("bp b0", 32'h0000_0500, 8'h99);
        tick();
        check("bp b done", 32'(bus.done), 32'd1);
        tick();
        tick();
        tick();
        check("bp b once", b_cnt,              32'd1);
        check("bp b idle", 32'(bus.mem_we),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
